// File: rtl/led_status_pkg.sv
// Shared definitions for the LED status front-end: display mode encodings,
// breathe-ramp state type and the all-LEDs-off pin level helper.
package led_status_pkg;

  localparam int LED_W = 4;

  localparam logic [1:0] MODE_COUNT    = 2'd0;
  localparam logic [1:0] MODE_BREATHE  = 2'd1;
  localparam logic [1:0] MODE_PATTERN  = 2'd2;
  localparam logic [1:0] MODE_ACTIVITY = 2'd3;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } breathe_state_t;

  // Pin level that leaves every LED dark for the given polarity.
  function automatic logic [LED_W-1:0] led_off(input bit active_low);
    return active_low ? {LED_W{1'b1}} : {LED_W{1'b0}};
  endfunction

endpackage

// File: rtl/led_status_driver_pwm_breathe.sv
// PWM generator with a triangle "breathing" duty ramp stepped on each tick.
// Optional macro LED_GAMMA_EN: square-law duty (duty*duty >> PWM_W),
// registered, adding one clock of delay to the effective duty only.
module led_pwm_breathe
  import led_status_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic pwm_on
);

  localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] DUTY_ONE = PWM_W'(1);
  localparam logic [PWM_W-1:0] DUTY_PEN = DUTY_MAX - DUTY_ONE;

  logic [PWM_W-1:0] r_pwm_cnt;
  logic [PWM_W-1:0] r_duty;
  logic [PWM_W-1:0] w_duty_nxt;
  logic [PWM_W-1:0] w_duty_eff;
  breathe_state_t   r_state;
  breathe_state_t   w_state_nxt;

  // Free-running PWM period counter.
  always_ff @(posedge clk) begin
    if (reset) r_pwm_cnt <= '0;
    else       r_pwm_cnt <= r_pwm_cnt + DUTY_ONE;
  end

  // Breathe state and duty registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RAMP_UP;
      r_duty  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
    end
  end

  // Triangle ramp: turn around on reaching either end so duty never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    if (tick) begin
      case (r_state)
        RAMP_UP: begin
          if (r_duty != DUTY_MAX) begin
            w_duty_nxt = r_duty + DUTY_ONE;
            if (r_duty == DUTY_PEN) w_state_nxt = RAMP_DOWN;
          end else begin
            w_state_nxt = RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (r_duty != '0) begin
            w_duty_nxt = r_duty - DUTY_ONE;
            if (r_duty == DUTY_ONE) w_state_nxt = RAMP_UP;
          end else begin
            w_state_nxt = RAMP_UP;
          end
        end
        default: w_state_nxt = RAMP_UP;
      endcase
    end
  end

`ifdef LED_GAMMA_EN
  logic [2*PWM_W-1:0] w_duty_sq;
  logic [PWM_W-1:0]   r_duty_eff_p1;

  assign w_duty_sq = {{PWM_W{1'b0}}, r_duty} * {{PWM_W{1'b0}}, r_duty};

  // ---- stage p1: registered square-law duty ----
  always_ff @(posedge clk) begin
    if (reset) r_duty_eff_p1 <= '0;
    else       r_duty_eff_p1 <= w_duty_sq[2*PWM_W-1:PWM_W];
  end

  assign w_duty_eff = r_duty_eff_p1;
`else
  assign w_duty_eff = r_duty;
`endif

  // Max duty leaves exactly one dark count per period.
  assign pwm_on = (r_pwm_cnt < w_duty_eff);

endmodule

// File: rtl/led_status_driver.sv
// Registered LED front-end: prescaler tick, 4-bit display counter, activity
// stretch and a mode mux feeding flopped LED pins.
// Optional macro LED_GAMMA_EN (in led_pwm_breathe): square-law PWM duty.
module led_status_driver
  import led_status_pkg::*;
#(
  parameter int PRESCALE_W    = 16,
  parameter int PWM_W         = 8,
  parameter int STRETCH_TICKS = 8,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [LED_W-1:0] pattern,
  input  logic             activity,
  output logic [LED_W-1:0] led_out,
  output logic             tick
);

  localparam int                    STRETCH_W    = $clog2(STRETCH_TICKS + 1);
  localparam logic [STRETCH_W-1:0]  STRETCH_LOAD = STRETCH_W'(STRETCH_TICKS);
  localparam logic [LED_W-1:0]      LED_OFF      = led_off(ACTIVE_LOW != 0);

  logic [PRESCALE_W-1:0] r_prescaler;
  logic                  r_tick;
  logic [3:0]            r_disp_cnt;
  logic [STRETCH_W-1:0]  r_stretch;
  logic [LED_W-1:0]      r_led;
  logic                  w_pwm_on;
  logic                  w_stretch_on;
  logic [LED_W-1:0]      w_lit;

  // Map "lit" bits onto pin levels for the board's LED polarity.
  function automatic logic [LED_W-1:0] to_pins(input logic [LED_W-1:0] lit);
    return (ACTIVE_LOW != 0) ? ~lit : lit;
  endfunction

  // Prescaler; tick is registered so it fires the cycle after all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescaler <= '0;
      r_tick      <= 1'b0;
    end else begin
      r_prescaler <= r_prescaler + PRESCALE_W'(1);
      r_tick      <= (r_prescaler == {PRESCALE_W{1'b1}});
    end
  end

  // Binary display counter advanced once per tick.
  always_ff @(posedge clk) begin
    if (reset)       r_disp_cnt <= 4'd0;
    else if (r_tick) r_disp_cnt <= r_disp_cnt + 4'd1;
  end

  // Activity stretch: a pulse reloads (beating a coincident tick decrement).
  always_ff @(posedge clk) begin
    if (reset)                          r_stretch <= '0;
    else if (activity)                  r_stretch <= STRETCH_LOAD;
    else if (r_tick && r_stretch != '0) r_stretch <= r_stretch - STRETCH_W'(1);
  end

  assign w_stretch_on = (r_stretch != '0);

  led_pwm_breathe #(
    .PWM_W (PWM_W)
  ) u_pwm_breathe (
    .clk    (clk),
    .reset  (reset),
    .tick   (r_tick),
    .pwm_on (w_pwm_on)
  );

  // Display mode select; counters keep running regardless of mode.
  always_comb begin
    w_lit = '0;
    case (mode)
      MODE_COUNT:    w_lit = r_disp_cnt;
      MODE_BREATHE:  w_lit = {LED_W{w_pwm_on}};
      MODE_PATTERN:  w_lit = pattern;
      MODE_ACTIVITY: w_lit = {r_disp_cnt[3:2], w_pwm_on, w_stretch_on};
      default:       w_lit = '0;
    endcase
  end

  // ---- output stage: LED pins driven straight from flops ----
  always_ff @(posedge clk) begin
    if (reset) r_led <= LED_OFF;
    else       r_led <= to_pins(w_lit);
  end

  assign led_out = r_led;
  assign tick    = r_tick;

endmodule

// File: tb/tb_led_status_driver.sv
// Scoreboard bench for led_status_driver with PRESCALE_W=4, PWM_W=3,
// STRETCH_TICKS=3, ACTIVE_LOW=1. The driver pushes the expected pin state
// for every clock; a monitor pops and compares after each rising edge.
module tb_led_status_driver;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [1:0] mode     = 2'd0;
  logic [3:0] pattern  = 4'd0;
  logic       activity = 1'b0;
  logic [3:0] led_out;
  logic       tick;

  always #5 clk = ~clk;

  led_status_driver #(
    .PRESCALE_W    (4),
    .PWM_W         (3),
    .STRETCH_TICKS (3),
    .ACTIVE_LOW    (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .pattern  (pattern),
    .activity (activity),
    .led_out  (led_out),
    .tick     (tick)
  );

  typedef struct packed {
    logic [3:0]  led;
    logic        tck;
    logic [63:0] tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference bookkeeping: edges since reset release, last stretch load.
  int   m_n      = 0;
  bit   m_loaded = 1'b0;
  int   m_tload  = 0;

  // Ticks consumed by the counters after n edges: edges 17, 33, 49, ...
  function automatic int tcount(input int n);
    return (n >= 17) ? (n - 1) / 16 : 0;
  endfunction

  // Triangle duty 0..7..0 with a 14-tick period.
  function automatic int duty_at(input int t);
    int p;
    p = t % 14;
    return (p <= 7) ? p : 14 - p;
  endfunction

  task automatic step(input bit rst, input logic [1:0] md, input logic [3:0] pat,
                      input bit act, input logic [63:0] tag);
    exp_t       e;
    int         t;
    int         duty;
    bit         pwm_on;
    bit         son;
    logic [3:0] dc;
    logic [3:0] lit;
    @(negedge clk);
    reset    = rst;
    mode     = md;
    pattern  = pat;
    activity = act;
    if (rst) begin
      e.led    = 4'hF;
      e.tck    = 1'b0;
      m_n      = 0;
      m_loaded = 1'b0;
    end else begin
      t  = tcount(m_n);
      dc = 4'(t % 16);
`ifdef LED_GAMMA_EN
      duty = (m_n == 0) ? 0 : (duty_at(tcount(m_n - 1)) * duty_at(tcount(m_n - 1))) / 8;
`else
      duty = duty_at(t);
`endif
      pwm_on = ((m_n % 8) < duty);
      son    = m_loaded && ((t - m_tload) < 3);
      case (md)
        2'd0:    lit = dc;
        2'd1:    lit = {4{pwm_on}};
        2'd2:    lit = pat;
        default: lit = {dc[3:2], pwm_on, son};
      endcase
      e.led = ~lit;
      e.tck = ((m_n + 1) % 16 == 0);
      if (act) begin
        m_loaded = 1'b1;
        m_tload  = tcount(m_n + 1);
      end
      m_n++;
    end
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: compare whatever the DUT shows against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        n_vec++;
        if (led_out !== mon_e.led || tick !== mon_e.tck) begin
          n_bad++;
          $display("FAIL %0s: led_out=%h tick=%b, required led_out=%h tick=%b",
                   mon_e.tag, led_out, tick, mon_e.led, mon_e.tck);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3)   step(1'b1, 2'd0, 4'h0, 1'b0, "reset");
    repeat (290) step(1'b0, 2'd0, 4'h0, 1'b0, "count");
    repeat (240) step(1'b0, 2'd1, 4'h0, 1'b0, "breathe");
    repeat (5)   step(1'b0, 2'd2, 4'b1010, 1'b0, "pat_1010");
    repeat (5)   step(1'b0, 2'd2, 4'b0001, 1'b0, "pat_0001");
    while (!((m_n % 16 == 0) && (m_n > 0)))
      step(1'b0, 2'd3, 4'h0, 1'b0, "act_wait");
    step(1'b0, 2'd3, 4'h0, 1'b1, "act_tick");
    repeat (24)  step(1'b0, 2'd3, 4'h0, 1'b0, "stretch");
    step(1'b0, 2'd3, 4'h0, 1'b1, "act_mid");
    repeat (70)  step(1'b0, 2'd3, 4'h0, 1'b0, "stretch2");
    while (duty_at(tcount(m_n)) != 5)
      step(1'b0, 2'd1, 4'h0, 1'b0, "ramp");
    repeat (3)   step(1'b0, 2'd1, 4'h0, 1'b0, "duty5");
    repeat (2)   step(1'b1, 2'd1, 4'h0, 1'b0, "rst_mid");
    repeat (40)  step(1'b0, 2'd1, 4'h0, 1'b0, "post_rst");
    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
